// File: rtl/reg_file_sb_pkg.sv
// Shared register-file constants and the architectural register address type,
// so decode, hazard and writeback units agree on sizing.
package rf_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_NRD   = 2;
    localparam int RF_AW    = $clog2(RF_NREGS);

    typedef logic [RF_AW-1:0] rf_addr_t;

endpackage : rf_pkg

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-side bundle of the scoreboarded register file: read ports,
// writeback write port, issue port and flush.
interface reg_file_sb_if
    import rf_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = RF_NRD,
    parameter int AW    = $clog2(NREGS)
);

    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;

    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;

    // Pipeline side: drives addresses, writes and issues; consumes read results.
    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_addr,
        output iss_en, iss_addr, flush,
        input  rd_data, rd_busy
    );

    // Register file side.
    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_addr,
        input  iss_en, iss_addr, flush,
        output rd_data, rd_busy
    );

endinterface : reg_file_sb_if

// File: rtl/reg_file_sb_read_port.sv
// One combinational read port: register-0 forcing, same-cycle write bypass and
// busy masking for the value being written back right now.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int AW   = RF_AW
) (
    input  logic            rst,
    input  logic [AW-1:0]   rd_addr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [XLEN-1:0] stored_data,
    input  logic            stored_busy,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_busy
);

    logic addr_zero;
    logic bypass;

    assign addr_zero = (rd_addr == '0);
    // Gated by reset so a write presented during reset never leaks out.
    assign bypass    = ~rst & wr_en & (wr_addr == rd_addr);

    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        rd_data = stored_data;
        rd_busy = stored_busy & ~bypass;
        if (addr_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if (bypass) begin
            rd_data = wr_data;
        end
    end

endmodule : rf_read_port

// File: rtl/reg_file_sb.sv
// Parametrised register file with NRD bypassed read ports, hardwired-zero r0 and
// a per-register busy scoreboard set at issue and cleared at writeback or flush.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = RF_NRD,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);

    logic [XLEN-1:0]          regs [NREGS];
    logic [NREGS-1:0]         busy;
    logic [NREGS-1:0]         busy_next;
    logic [NRD-1:0][XLEN-1:0] port_data;
    logic [NRD-1:0]           port_busy;

    // NOTE: the array is reset because software may read any register before
    // writing it and must observe zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (bus.wr_en && bus.wr_addr != '0) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Issue is applied after writeback so a same-cycle re-issue stays busy.
    always_comb begin
        busy_next = busy;
        if (bus.flush) begin
            busy_next = '0;
        end else begin
            if (bus.wr_en) begin
                busy_next[bus.wr_addr] = 1'b0;
            end
            if (bus.iss_en && bus.iss_addr != '0) begin
                busy_next[bus.iss_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;

        assign addr = bus.rd_addr[i*AW +: AW];

        rf_read_port #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_port (
            .rst         (rst),
            .rd_addr     (addr),
            .wr_en       (bus.wr_en),
            .wr_addr     (bus.wr_addr),
            .wr_data     (bus.wr_data),
            .stored_data (regs[addr]),
            .stored_busy (busy[addr]),
            .rd_data     (port_data[i]),
            .rd_busy     (port_busy[i])
        );
    end

    assign bus.rd_data = port_data;
    assign bus.rd_busy = port_busy;

endmodule : reg_file_sb
